// File: rtl/count_seq_ctrl.sv
// Move sequencer for an N-bit up/down counter: accepts a target over valid/ready
// and steps the counter once per prescaled tick along the shortest modular path.
module count_seq_ctrl #(
   parameter int N        = 8,
   parameter int STEP_DIV = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cmd_valid,
   input  logic [N-1:0] cmd_target,
   output logic         cmd_ready,
   input  logic         abort,
   input  logic [N-1:0] count,
   output logic         cnt_en,
   output logic         cnt_cw,
   output logic         busy,
   output logic         done,
   output logic         aborted,
   output logic [1:0]   dbg_state
);

   // Handshake: a command transfers on any rising edge where cmd_valid && cmd_ready;
   // cmd_ready is high only in IDLE, and nothing is queued while it is low.
   localparam int            PW      = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [PW-1:0] PC_LAST = PW'(STEP_DIV - 1);
   localparam logic [N-1:0]  HALF    = {1'b1, {(N-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DONE  = 2'd2,
      S_ABORT = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  target_q, target_d;
   logic          dir_q, dir_d;
   logic [PW-1:0] pc_q, pc_d;

   logic [N-1:0]  diff;
   logic          tick;
   logic          at_target;

   assign diff      = cmd_target - count;
   assign tick      = (pc_q == PC_LAST);
   assign at_target = (count == target_q);
   assign dbg_state = state_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         target_q <= '0;
         dir_q    <= 1'b0;
         pc_q     <= '0;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         dir_q    <= dir_d;
         pc_q     <= pc_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      target_d  = target_q;
      dir_d     = dir_q;
      pc_d      = '0;
      cmd_ready = 1'b0;
      busy      = 1'b1;
      cnt_en    = 1'b0;
      done      = 1'b0;
      aborted   = 1'b0;
      case (state_q)
         S_IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            if (cmd_valid) begin
               target_d = cmd_target;
               if (diff == '0) begin
                  state_d = S_DONE;
               end else begin
                  // The exact half-way tie resolves upward.
                  dir_d   = (diff <= HALF);
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            pc_d   = tick ? '0 : pc_q + 1'b1;
            cnt_en = tick && !at_target && !abort;
            if (abort) begin
               state_d = S_ABORT;
            end else if (at_target) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         S_ABORT: begin
            aborted = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign cnt_cw = (state_q != S_IDLE) && dir_q;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Bench for count_seq_ctrl: a behavioural counter closes the loop, a vector table
// covers plain moves, and hand-written sequences cover zero-distance, abort and reset.
module tb_count_seq_ctrl;

   localparam int N  = 8;
   localparam int SD = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         cmd_valid = 1'b0;
   logic [N-1:0] cmd_target = '0;
   logic         cmd_ready;
   logic         abort = 1'b0;
   logic [N-1:0] count = '0;
   logic         cnt_en, cnt_cw, busy, done, aborted;
   logic [1:0]   dbg_state;

   logic         ld = 1'b0;
   logic [N-1:0] ld_val = '0;
   int           cyc = 0;
   int           checks = 0;
   int           errors = 0;

   count_seq_ctrl #(.N(N), .STEP_DIV(SD)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_target(cmd_target),
      .cmd_ready(cmd_ready), .abort(abort), .count(count), .cnt_en(cnt_en),
      .cnt_cw(cnt_cw), .busy(busy), .done(done), .aborted(aborted),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Counter datapath model, unaffected by the controller reset.
   always @(posedge clk) begin
      if (ld) count <= ld_val;
      else if (cnt_en) count <= cnt_cw ? count + 8'd1 : count - 8'd1;
   end

   typedef struct {
      logic [N-1:0] start;
      logic [N-1:0] target;
      logic         dir;
      int           steps;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic load_count(input logic [N-1:0] v);
      ld_val = v;
      ld = 1'b1;
      @(posedge clk); #1;
      ld = 1'b0;
      @(posedge clk); #1;
   endtask

   // Drives a command for one cycle; returns the acceptance cycle.
   task automatic issue(input logic [N-1:0] tgt, output int t0);
      cmd_valid  = 1'b1;
      cmd_target = tgt;
      t0 = cyc;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   // Called during cycle t0+1; follows the move to completion.
   task automatic watch(input string nm, input int t0, input logic dir,
                        input int steps, input logic [N-1:0] tgt);
      int pulses = 0;
      int done_t = -1;
      int rel;
      for (int i = 0; i < SD * steps + 10; i++) begin
         @(negedge clk);
         rel = cyc - t0;
         if (cnt_en) begin
            pulses++;
            chk({nm, " en_time"}, rel, SD * pulses);
            chk({nm, " cw"}, int'(cnt_cw), int'(dir));
         end
         if (done) begin
            done_t = rel;
            break;
         end
      end
      chk({nm, " done_time"}, done_t, SD * steps + 2);
      chk({nm, " pulses"}, pulses, steps);
      chk({nm, " count"}, int'(count), int'(tgt));
      @(negedge clk);
      chk({nm, " ready_back"}, int'(cmd_ready), 1);
      chk({nm, " busy_low"}, int'(busy), 0);
   endtask

   initial begin
      int t0, t2;

      vecs[0] = '{start: 8'd10,  target: 8'd13,  dir: 1'b1, steps: 3};
      vecs[1] = '{start: 8'd250, target: 8'd3,   dir: 1'b1, steps: 9};
      vecs[2] = '{start: 8'd3,   target: 8'd250, dir: 1'b0, steps: 9};
      vecs[3] = '{start: 8'd0,   target: 8'd128, dir: 1'b1, steps: 128};
      vecs[4] = '{start: 8'd128, target: 8'd0,   dir: 1'b1, steps: 128};
      vecs[5] = '{start: 8'd5,   target: 8'd4,   dir: 1'b0, steps: 1};
      vecs[6] = '{start: 8'd0,   target: 8'd255, dir: 1'b0, steps: 1};

      // Reset state
      #1;
      chk("rst cmd_ready", int'(cmd_ready), 1);
      chk("rst busy", int'(busy), 0);
      chk("rst cnt_en", int'(cnt_en), 0);
      chk("rst cnt_cw", int'(cnt_cw), 0);
      chk("rst done", int'(done), 0);
      chk("rst aborted", int'(aborted), 0);
      chk("rst state", int'(dbg_state), 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // Table-driven moves
      for (int v = 0; v < 7; v++) begin
         load_count(vecs[v].start);
         issue(vecs[v].target, t0);
         watch($sformatf("vec%0d", v), t0, vecs[v].dir, vecs[v].steps, vecs[v].target);
      end

      // Zero distance with a back-to-back command
      load_count(8'd77);
      issue(8'd77, t0);
      cmd_valid  = 1'b1;
      cmd_target = 8'd78;
      @(negedge clk);
      chk("zero done", int'(done), 1);
      chk("zero cmd_ready", int'(cmd_ready), 0);
      chk("zero cnt_en", int'(cnt_en), 0);
      chk("zero done_cycle", cyc - t0, 1);
      @(negedge clk);
      chk("zero busy_low", int'(busy), 0);
      chk("zero ready_back", int'(cmd_ready), 1);
      chk("zero done_once", int'(done), 0);
      chk("zero count", int'(count), 77);
      t2 = cyc;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      chk("b2b accept_gap", t2 - t0, 2);
      watch("b2b", t2, 1'b1, 1, 8'd78);

      // Abort mid-move, with a command held during RUN
      load_count(8'd10);
      issue(8'd20, t0);
      cmd_valid  = 1'b1;
      cmd_target = 8'd99;
      repeat (8) @(posedge clk);
      #1 abort = 1'b1;
      chk("abort at_cycle", cyc - t0, 9);
      @(negedge clk);
      chk("abort cnt_en", int'(cnt_en), 0);
      chk("abort busy", int'(busy), 1);
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      chk("abort pulse", int'(aborted), 1);
      chk("abort no_done", int'(done), 0);
      chk("abort count", int'(count), 12);
      chk("abort held_cmd_ready", int'(cmd_ready), 0);
      @(negedge clk);
      chk("abort idle_ready", int'(cmd_ready), 1);
      chk("abort pulse_once", int'(aborted), 0);
      t2 = cyc;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      chk("held accept_cycle", t2 - t0, 11);
      @(negedge clk);
      chk("held accepted_busy", int'(busy), 1);
      chk("held dir_up", int'(cnt_cw), 1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      abort = 1'b1;
      chk("tick_abort cycle", cyc - t2, 4);
      @(negedge clk);
      chk("tick_abort cnt_en", int'(cnt_en), 0);
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      chk("tick_abort pulse", int'(aborted), 1);
      chk("tick_abort count", int'(count), 12);
      @(negedge clk);

      // Asynchronous reset mid-move
      load_count(8'd10);
      issue(8'd20, t0);
      repeat (5) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("mid_rst cycle", cyc - t0, 6);
      chk("mid_rst cnt_en", int'(cnt_en), 0);
      chk("mid_rst cnt_cw", int'(cnt_cw), 0);
      chk("mid_rst busy", int'(busy), 0);
      chk("mid_rst cmd_ready", int'(cmd_ready), 1);
      chk("mid_rst done", int'(done), 0);
      chk("mid_rst aborted", int'(aborted), 0);
      chk("mid_rst count", int'(count), 11);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      repeat (8) begin
         @(negedge clk);
         if (done || aborted || cnt_en) chk("post_rst quiet", 1, 0);
      end
      chk("post_rst ready", int'(cmd_ready), 1);
      chk("post_rst state", int'(dbg_state), 0);
      chk("post_rst count", int'(count), 11);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/count_seq_ctrl.md
# count_seq_ctrl

Move sequencer for the N-bit up/down counter datapath. It accepts "go to target value" commands over a valid/ready handshake and drives the counter's `en`/`cw` controls one step per prescaled tick along the shortest modular path. It compares the counter's live `count` against the target and reports completion or abort. It is the sole owner of the counter's `en` and `cw` inputs.

## Interface
- `N`, 8: counter/target width in bits; must match the controlled counter.
- `STEP_DIV`, 4: clock cycles per step opportunity; legal range 2..65535.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset (asserts immediately when low, releases synchronously to design state).
- `cmd_valid` in 1: command present.
- `cmd_target` in N: target count value.
- `cmd_ready` out 1: high only in IDLE.
- `abort` in 1: cancel the move in progress.
- `count` in N: current counter value.
- `cnt_en` out 1: counter step enable.
- `cnt_cw` out 1: counter direction; 1 = up, 0 = down.
- `busy` out 1: state is not IDLE.
- `done` out 1: one-cycle pulse, move completed.
- `aborted` out 1: one-cycle pulse, move cancelled.

## Operation
- FSM states are IDLE, RUN, DONE and ABORT. Reset value is IDLE. Registered state: `target_q`, `dir_q`, prescaler `pc` (width ceil(log2(STEP_DIV))).
- Acceptance happens when `cmd_valid && cmd_ready`. On acceptance:
  - latch `target_q = cmd_target`;
  - compute `diff = (cmd_target - count) mod 2^N` (N-bit wrap subtraction);
  - `diff == 0`: go to DONE, no step issued;
  - `1 <= diff <= 2^(N-1)`: `dir_q = 1` (up); the tie at exactly 2^(N-1) goes up;
  - `diff > 2^(N-1)`: `dir_q = 0` (down);
  - nonzero diff: go to RUN with `pc = 0`.
- RUN behaviour:
  - `pc` increments each cycle and wraps to 0 after STEP_DIV-1. A tick occurs when `pc == STEP_DIV-1`.
  - `cnt_en = (state==RUN) && tick && (count != target_q) && !abort` (combinational).
  - `cnt_cw = dir_q` whenever `busy`, else 0.
  - If `abort`: next state is ABORT. Abort has priority over completion.
  - Else if `count == target_q`: next state is DONE. This is checked every cycle, not only on ticks.
- DONE: `done = 1` for exactly one cycle, then IDLE.
- ABORT: `aborted = 1` for exactly one cycle, then IDLE. The counter keeps its partial value.
- `abort` is ignored in IDLE, DONE and ABORT. `cmd_valid` is ignored while `cmd_ready = 0`; there is no queuing.
- Counter passes through 2^N-1 ↔ 0 on wrap. The controller compares equality only, so wrap needs no special handling.
- Outputs during and after reset: `cnt_en = 0`, `cnt_cw = 0`, `busy = 0`, `done = 0`, `aborted = 0`, `cmd_ready = 1`; `target_q`, `dir_q` and `pc` are 0.
- Reset asserted mid-move returns the FSM to IDLE immediately with `cnt_en` low and no `done`/`aborted` pulse. The counter value is not touched.

## Timing
- Let T be the acceptance cycle and d the shortest-path distance (d >= 1).
- RUN occupies cycles T+1 onward. `cnt_en` pulses at cycles T+k·STEP_DIV for k = 1..d, one cycle each.
- `count` reaches the target after the edge ending cycle T+d·STEP_DIV.
- `count == target_q` is seen in cycle T+d·STEP_DIV+1, so `done` is high in cycle T+d·STEP_DIV+2. IDLE and `cmd_ready` return in cycle T+d·STEP_DIV+3.
- Zero-distance command: `done` is high in cycle T+1 and `cmd_ready` returns in T+2.
- Abort sampled high in RUN cycle A: `aborted` is high in cycle A+1, IDLE in A+2. `cnt_en` is forced low in cycle A.
- STEP_DIV >= 2 guarantees the counter has updated before the next enable decision, so no overshoot is possible.
- Minimum command-to-command spacing: 2 cycles (zero-distance case).

## Test plan
- N=8, STEP_DIV=4, count=10, target=13, accept at T: `cnt_cw=1`; `cnt_en` at T+4, T+8, T+12; `done` at T+14; `count=13`; `cmd_ready=1` at T+15.
- Up wrap, count=250, target=3: diff=9, up; count goes 250…255, 0…3 over 9 `cnt_en` pulses; `done` at T+38.
- Down wrap and tie:
  - count=3, target=250: diff=247, so down, 9 steps;
  - count=0, target=128: tie, so up, 128 steps, `done` at T+514.
- Zero distance, count=target=77: no `cnt_en`; `done` at T+1; `busy` low at T+2; a back-to-back command is accepted at T+2.
- Abort, count=10, target=20: `abort` asserted in cycle T+9 gives `count=12`, `aborted` at T+10, no `done`; `cmd_valid` held during RUN is not accepted until IDLE.
- Reset mid-move (`rst` low at T+6, async): all outputs drop to reset values within the same cycle; after release, IDLE with `cmd_ready=1` and the counter value unchanged by the controller.
